btn_debounce_pulse: RTL and testbench

Input conditioning stage that sits directly upstream of the set/reset latch. It takes a raw, asynchronous, bouncing push-button signal and synchronises it to `clk`, then debounces it. It produces a clean level plus single-cycle press/release pulses; `press_pulse` drives the latch `set` input. With the optional feature enabled, it also flags long presses.

---
 rtl/btn_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/btn_debounce_pulse.sv | 145 ++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioning blocks.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_LONG_CYCLES     = 1000;
  localparam int DEF_ACTIVE_LOW      = 0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  // Stage 0 may go metastable; stage 1 gives it a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button synchroniser + debounce FSM with registered level and press/release strobes.
// Optional long-press strobe enabled by defining BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
  // stab_cnt counts stable samples already accepted; the current sample completes the run.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

  logic btn_pol;
  logic btn_s;

  state_t            state, state_nxt;
  logic [STAB_W-1:0] stab_cnt, stab_nxt;
  logic              level_nxt;
  logic              press_nxt;
  logic              release_nxt;

  assign btn_pol = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_pol),
    .q    (btn_s)
  );

  always_comb begin
    state_nxt   = state;
    stab_nxt    = stab_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          stab_nxt  = STAB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          stab_nxt  = '0;
        end else if (stab_cnt >= STAB_LAST) begin
          state_nxt = PRESSED;
          stab_nxt  = '0;
          press_nxt = 1'b1;
        end else begin
          stab_nxt = stab_cnt + STAB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          stab_nxt  = STAB_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          stab_nxt  = '0;
        end else if (stab_cnt >= STAB_LAST) begin
          state_nxt   = IDLE;
          stab_nxt    = '0;
          release_nxt = 1'b1;
        end else begin
          stab_nxt = stab_cnt + STAB_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        stab_nxt  = '0;
      end
    endcase
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  // Outputs are registered from the next-state decode so they align with the state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      stab_cnt      <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      stab_cnt      <= stab_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              long_nxt;

  // Bouncing back from RELEASE_WAIT keeps the count; only a fresh press or confirmed release clears it.
  always_comb begin
    hold_nxt = hold_cnt;
    long_nxt = 1'b0;
    if (state == PRESS_WAIT && state_nxt == PRESSED) begin
      hold_nxt = '0;
    end else if (state_nxt == IDLE) begin
      hold_nxt = '0;
    end else if ((state == PRESSED || state == RELEASE_WAIT) && hold_cnt != HOLD_MAX) begin
      hold_nxt = hold_cnt + HOLD_W'(1);
      long_nxt = (hold_nxt == HOLD_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      hold_cnt   <= hold_nxt;
      long_pulse <= long_nxt;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench: active-high and active-low instances driven with mirrored raw inputs.
module tb_btn_debounce_pulse;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic raw_a;
  logic raw_b;
  logic level_a, press_a, release_a, long_a;
  logic level_b, press_b, release_b, long_b;

  int checks = 0;
  int errors = 0;
  int press_count;

  always #5 clk = ~clk;

  assign raw_b = ~raw_a;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (0)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (raw_a),
    .level        (level_a),
    .press_pulse  (press_a),
    .release_pulse(release_a),
    .long_pulse   (long_a)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (raw_b),
    .level        (level_b),
    .press_pulse  (press_b),
    .release_pulse(release_b),
    .long_pulse   (long_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input bit lv, input bit pr, input bit rl, input bit lg);
    check({tag, " a.level"},   int'(level_a),   int'(lv));
    check({tag, " a.press"},   int'(press_a),   int'(pr));
    check({tag, " a.release"}, int'(release_a), int'(rl));
    check({tag, " a.long"},    int'(long_a),    int'(lg));
    check({tag, " b.level"},   int'(level_b),   int'(lv));
    check({tag, " b.press"},   int'(press_b),   int'(pr));
    check({tag, " b.release"}, int'(release_b), int'(rl));
    check({tag, " b.long"},    int'(long_b),    int'(lg));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    raw_a = 1'b0;
    repeat (3) step();
    expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) step();
    expect_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press held long enough for a long-press strobe.
    raw_a = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step();
      expect_all($sformatf("press e%0d", i), i >= 5, i == 5, 1'b0, LONG_EN && (i == 15));
    end

    // Clean release.
    raw_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_all($sformatf("release e%0d", i), i < 5, 1'b0, i == 5, 1'b0);
    end
    repeat (3) step();
    expect_all("idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Bounce: 1,1,0 then held 1; final rise sampled at edge 3.
    press_count = 0;
    for (int j = 0; j < 11; j++) begin
      raw_a = (j != 2);
      step();
      if (press_a) press_count++;
      expect_all($sformatf("bounce e%0d", j), j >= 8, j == 8, 1'b0, 1'b0);
    end
    check("bounce press count", press_count, 1);

    // Reset while PRESSED with the button still held.
    repeat (2) step();
    reset = 1'b1;
    step();
    expect_all("reset mid-press", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      step();
      expect_all("reset held", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_all($sformatf("repress e%0d", i), i >= 6, i == 6, 1'b0, 1'b0);
    end

    raw_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_all($sformatf("release2 e%0d", i), i < 5, 1'b0, i == 5, 1'b0);
    end

    // Toggling every cycle never completes a debounce window.
    for (int k = 0; k < 20; k++) begin
      raw_a = k[0];
      step();
      expect_all($sformatf("toggle e%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
